// File: rtl/keyboard_decoder_if.sv
// Scancode FIFO handshake plus decoded keyboard state between the FIFO side
// (master) and the keyboard_decoder (slave).
interface keyboard_decoder_if #(
  parameter int DATA_W = 8
);
  logic              ready;
  logic              overflow;
  logic [DATA_W-1:0] data;
  logic              set_rst;
  logic              set_next;
  logic              ctrl;
  logic              alt;
  logic              shift;
  logic              caps;
  logic [DATA_W-1:0] key;

  modport master (
    output ready, overflow, data,
    input  set_rst, set_next, ctrl, alt, shift, caps, key
  );

  modport slave (
    input  ready, overflow, data,
    output set_rst, set_next, ctrl, alt, shift, caps, key
  );
endinterface

// File: rtl/keyboard_decoder.sv
// PS/2 set-2 scancode decoder: pops bytes from a scancode FIFO, tracks E0/F0
// prefixes, modifier keys, Caps Lock toggle and the currently held key.
module keyboard_decoder (
  input  logic               clk,
  input  logic               rst,
  keyboard_decoder_if.slave  kb
);

  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SC_EXT    = 8'hE0;
  localparam logic [DATA_W-1:0] SC_BRK    = 8'hF0;
  localparam logic [DATA_W-1:0] SC_LSHIFT = 8'h12;
  localparam logic [DATA_W-1:0] SC_RSHIFT = 8'h59;
  localparam logic [DATA_W-1:0] SC_CTRL   = 8'h14;
  localparam logic [DATA_W-1:0] SC_ALT    = 8'h11;
  localparam logic [DATA_W-1:0] SC_CAPS   = 8'h58;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    OVF  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              ext, ext_n;
  logic              brk, brk_n;
  logic              lshift, lshift_n, rshift, rshift_n;
  logic              lctrl, lctrl_n, rctrl, rctrl_n;
  logic              lalt, lalt_n, ralt, ralt_n;
  logic              caps, caps_n;
  logic              caps_held, caps_held_n;
  logic [DATA_W-1:0] key, key_n;
  logic              set_next_n, set_rst_n;
  logic              set_next_q, set_rst_q;
  logic              ctrl_q, alt_q, shift_q;

  // Keyboard self-test / ack / echo / resend / error bytes carry no key info.
  function automatic logic is_ignored(input logic [DATA_W-1:0] b);
    return (b == 8'h00) || (b == 8'hAA) || (b == 8'hEE) ||
           (b == 8'hFA) || (b == 8'hFE) || (b == 8'hFF);
  endfunction

  always_comb begin
    state_n     = state;
    ext_n       = ext;
    brk_n       = brk;
    lshift_n    = lshift;
    rshift_n    = rshift;
    lctrl_n     = lctrl;
    rctrl_n     = rctrl;
    lalt_n      = lalt;
    ralt_n      = ralt;
    caps_n      = caps;
    caps_held_n = caps_held;
    key_n       = key;
    set_next_n  = 1'b0;
    set_rst_n   = 1'b0;

    case (state)
      IDLE: begin
        if (kb.overflow) begin
          // Overflow wins over a pending byte; modifiers survive the flush.
          state_n   = OVF;
          set_rst_n = 1'b1;
          ext_n     = 1'b0;
          brk_n     = 1'b0;
          key_n     = '0;
        end else if (kb.ready) begin
          state_n    = POP;
          set_next_n = 1'b1;
          if (kb.data == SC_EXT) begin
            ext_n = 1'b1;
          end else if (kb.data == SC_BRK) begin
            brk_n = 1'b1;
          end else begin
            ext_n = 1'b0;
            brk_n = 1'b0;
            if (!(!ext && !brk && is_ignored(kb.data))) begin
              case (kb.data)
                SC_LSHIFT: if (!ext) lshift_n = !brk;
                SC_RSHIFT: if (!ext) rshift_n = !brk;
                SC_CTRL: begin
                  if (ext) rctrl_n = !brk;
                  else     lctrl_n = !brk;
                end
                SC_ALT: begin
                  if (ext) ralt_n = !brk;
                  else     lalt_n = !brk;
                end
                SC_CAPS: begin
                  if (!ext) begin
                    if (brk) begin
                      caps_held_n = 1'b0;
                    end else if (!caps_held) begin
                      caps_n      = !caps;
                      caps_held_n = 1'b1;
                    end
                  end
                end
                default: begin
                  if (!ext) begin
                    if (!brk)                 key_n = kb.data;
                    else if (kb.data == key)  key_n = '0;
                  end
                end
              endcase
            end
          end
        end
      end
      POP:     state_n = IDLE;
      OVF:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ext        <= 1'b0;
      brk        <= 1'b0;
      lshift     <= 1'b0;
      rshift     <= 1'b0;
      lctrl      <= 1'b0;
      rctrl      <= 1'b0;
      lalt       <= 1'b0;
      ralt       <= 1'b0;
      caps       <= 1'b0;
      caps_held  <= 1'b0;
      key        <= '0;
      set_next_q <= 1'b0;
      set_rst_q  <= 1'b0;
      ctrl_q     <= 1'b0;
      alt_q      <= 1'b0;
      shift_q    <= 1'b0;
    end else begin
      state      <= state_n;
      ext        <= ext_n;
      brk        <= brk_n;
      lshift     <= lshift_n;
      rshift     <= rshift_n;
      lctrl      <= lctrl_n;
      rctrl      <= rctrl_n;
      lalt       <= lalt_n;
      ralt       <= ralt_n;
      caps       <= caps_n;
      caps_held  <= caps_held_n;
      key        <= key_n;
      set_next_q <= set_next_n;
      set_rst_q  <= set_rst_n;
      ctrl_q     <= lctrl_n | rctrl_n;
      alt_q      <= lalt_n | ralt_n;
      shift_q    <= lshift_n | rshift_n;
    end
  end

  assign kb.set_next = set_next_q;
  assign kb.set_rst  = set_rst_q;
  assign kb.ctrl     = ctrl_q;
  assign kb.alt      = alt_q;
  assign kb.shift    = shift_q;
  assign kb.caps     = caps;
  assign kb.key      = key;

endmodule

// File: tb/tb_keyboard_decoder.sv
// Directed-vector bench for keyboard_decoder: scancode sequences with
// hand-computed modifier, caps and key expectations.
module tb_keyboard_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  keyboard_decoder_if kb ();

  keyboard_decoder dut (
    .clk (clk),
    .rst (rst),
    .kb  (kb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".set_rst"},  {7'd0, kb.set_rst},  8'h00);
    chk({tag, ".set_next"}, {7'd0, kb.set_next}, 8'h00);
    chk({tag, ".ctrl"},     {7'd0, kb.ctrl},     8'h00);
    chk({tag, ".alt"},      {7'd0, kb.alt},      8'h00);
    chk({tag, ".shift"},    {7'd0, kb.shift},    8'h00);
    chk({tag, ".caps"},     {7'd0, kb.caps},     8'h00);
    chk({tag, ".key"},      kb.key,              8'h00);
  endtask

  // Called at a falling edge with the decoder in IDLE; returns two cycles later.
  task automatic send_byte(input logic [7:0] b);
    kb.ready = 1'b1;
    kb.data  = b;
    @(negedge clk);
    chk("set_next_pulse", {7'd0, kb.set_next}, 8'h01);
    chk("set_rst_quiet",  {7'd0, kb.set_rst},  8'h00);
    @(negedge clk);
    chk("set_next_drop",  {7'd0, kb.set_next}, 8'h00);
    kb.ready = 1'b0;
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    chk(tag, {7'd0, got}, {7'd0, exp});
  endtask

  initial begin
    kb.ready    = 1'b0;
    kb.overflow = 1'b0;
    kb.data     = 8'h00;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Make then break of a plain key
    send_byte(8'h1C); chk("mk_1c", kb.key, 8'h1C);
    send_byte(8'hF0); chk("f0_pending", kb.key, 8'h1C);
    send_byte(8'h1C); chk("brk_1c", kb.key, 8'h00);

    // Shift + key, typematic repeat, shift release
    send_byte(8'h12); chk_bit("shift_mk", kb.shift, 1'b1);
    send_byte(8'h1C); chk("key_with_shift", kb.key, 8'h1C);
    chk_bit("shift_held", kb.shift, 1'b1);
    send_byte(8'h1C); chk("key_repeat", kb.key, 8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    chk_bit("shift_brk", kb.shift, 1'b0);
    chk("key_after_shift_brk", kb.key, 8'h1C);
    send_byte(8'hF0); send_byte(8'h1C);
    chk("key_clear", kb.key, 8'h00);

    // Right/left ctrl
    send_byte(8'hE0); send_byte(8'h14); chk_bit("rctrl_mk", kb.ctrl, 1'b1);
    send_byte(8'h14); chk_bit("lctrl_mk", kb.ctrl, 1'b1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
    chk_bit("rctrl_brk_lheld", kb.ctrl, 1'b1);
    send_byte(8'hF0); send_byte(8'h14); chk_bit("lctrl_brk", kb.ctrl, 1'b0);
    chk("ctrl_key_untouched", kb.key, 8'h00);

    // Right/left alt
    send_byte(8'hE0); send_byte(8'h11); chk_bit("ralt_mk", kb.alt, 1'b1);
    send_byte(8'hF0); send_byte(8'h11); chk_bit("lalt_brk_rheld", kb.alt, 1'b1);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h11);
    chk_bit("ralt_brk", kb.alt, 1'b0);

    // Caps Lock toggle behaviour
    send_byte(8'h58); chk_bit("caps_on", kb.caps, 1'b1);
    send_byte(8'h58); chk_bit("caps_repeat", kb.caps, 1'b1);
    send_byte(8'hF0); send_byte(8'h58); chk_bit("caps_brk", kb.caps, 1'b1);
    send_byte(8'h58); chk_bit("caps_off", kb.caps, 1'b0);
    send_byte(8'hF0); send_byte(8'h58);
    chk("caps_key_untouched", kb.key, 8'h00);

    // Ignored and extended bytes, foreign breaks
    send_byte(8'h1C);
    send_byte(8'hAA); chk("ign_aa", kb.key, 8'h1C);
    send_byte(8'hFA); chk("ign_fa", kb.key, 8'h1C);
    send_byte(8'hE0); send_byte(8'h75); chk("ext_ign", kb.key, 8'h1C);
    send_byte(8'h75); chk("ext_cleared", kb.key, 8'h75);
    send_byte(8'hF0); send_byte(8'h1C); chk("other_brk", kb.key, 8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    chk("ext_brk_ign", kb.key, 8'h75);
    send_byte(8'hF0); send_byte(8'h75); chk("brk_75", kb.key, 8'h00);

    // Overflow after F0 with key held; modifiers survive
    send_byte(8'h59); send_byte(8'h58); send_byte(8'h1C); send_byte(8'hF0);
    kb.overflow = 1'b1;
    kb.ready    = 1'b1;
    kb.data     = 8'h1C;
    @(negedge clk);
    chk_bit("ovf_set_rst", kb.set_rst, 1'b1);
    chk_bit("ovf_no_next", kb.set_next, 1'b0);
    chk("ovf_key", kb.key, 8'h00);
    chk_bit("ovf_shift_kept", kb.shift, 1'b1);
    chk_bit("ovf_caps_kept", kb.caps, 1'b1);
    kb.overflow = 1'b0;
    kb.ready    = 1'b0;
    @(negedge clk);
    chk_bit("ovf_set_rst_drop", kb.set_rst, 1'b0);
    send_byte(8'h1C); chk("ovf_then_make", kb.key, 8'h1C);

    // Asynchronous reset between edges
    #2 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    chk_all_zero("rst_hold");
    rst = 1'b0;
    // caps_held must have cleared, so this press toggles
    send_byte(8'h58); chk_bit("caps_after_rst", kb.caps, 1'b1);

    // Reset discards a pending break prefix
    send_byte(8'h1C);
    send_byte(8'hF0);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h1C); chk("prefix_discard", kb.key, 8'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keyboard_decoder.md
KEYBOARD_DECODER -- requirements
Module: keyboard_decoder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ready  input  1  the scancode FIFO holds at least one byte; data is valid while ready=1.
REQ-005 overflow  input  1  the scancode FIFO has overflowed.
REQ-006 data  input  8  PS/2 set-2 scancode byte at the FIFO head.
REQ-007 set_rst  output  1  registered one-cycle pulse that resets the FIFO.
REQ-008 set_next  output  1  registered one-cycle pulse that pops the FIFO head.
REQ-009 ctrl, alt, shift  output  1 each  level: left OR right modifier currently held.
REQ-010 caps  output  1  Caps Lock toggle state.
REQ-011 key  output  8  make code of the currently held non-modifier key; 0x00 when no such key is held.

Function
REQ-012 FSM states SHALL be: IDLE, POP, OVF.
REQ-013 Prefix flags SHALL be: ext (after 0xE0) and brk (after 0xF0).
REQ-014 In IDLE with overflow=1, the next state SHALL be OVF, and overflow SHALL take priority over ready.
- Actions: set_rst=1 for exactly that one cycle; ext, brk and key cleared.
- ctrl, alt, shift and caps SHALL keep their values.
- OVF SHALL return to IDLE unconditionally.
REQ-015 In IDLE with ready=1 and overflow=0, the byte on data SHALL be processed in that cycle (REQ-017..REQ-024).
- Next state SHALL be POP, with set_next=1 for exactly one cycle.
- POP SHALL return to IDLE and ignore ready.
- Maximum throughput SHALL be one byte per 2 clocks.
REQ-016 set_next and set_rst SHALL never be high in the same cycle.
REQ-017 Byte 0xE0: set ext, with no other effect.
REQ-018 Byte 0xF0: set brk, with no other effect.
REQ-019 Any other byte SHALL be interpreted with the current ext/brk flags, and both flags SHALL then clear.
REQ-020 Modifier codes: 0x12 = left shift; 0x59 = right shift; 0x14 = left ctrl (right ctrl when ext=1); 0x11 = left alt (right alt when ext=1).
- Make (brk=0) SHALL set the individual held flag; break (brk=1) SHALL clear it.
- The key output SHALL be unaffected.
REQ-021 Caps Lock (0x58, ext=0):
- Make while not already held SHALL toggle caps and set caps_held.
- A repeated make while held SHALL NOT toggle.
- Break SHALL clear caps_held.
- The key output SHALL be unaffected.
REQ-022 Non-modifier, non-extended make SHALL set key to data; a typematic repeat leaves key unchanged.
REQ-023 Non-modifier break whose code equals key SHALL set key to 0x00; a break of any other code SHALL leave key unchanged.
REQ-024 Ignored bytes:
- With ext=0 and brk=0: 0x00, 0xAA, 0xEE, 0xFA, 0xFE, 0xFF SHALL be ignored.
- Extended non-modifier codes SHALL be ignored, though the flags still clear.
REQ-025 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-026 While rst=1, the block SHALL hold:
- State = IDLE.
- set_rst=0, set_next=0, ctrl=0, alt=0, shift=0, caps=0, key=0x00.
- ext, brk and caps_held cleared.
REQ-027 An assertion mid-sequence (e.g. after 0xF0) SHALL discard the pending prefix immediately.
REQ-028 After deassertion, the first byte SHALL be accepted on the first rising edge with ready=1.

Verification
REQ-029 Bytes 0x1C then F0 1C, each presented while ready=1 -> key=0x1C after the first byte, 0x00 after the break; set_next pulses once per byte, 2 cycles apart.
REQ-030 Bytes 12, 1C, 1C, F0 12 -> shift=1 and key=0x1C after the first two bytes; key stays 0x1C on the repeat; shift=0 after the break while key remains 0x1C.
REQ-031 Bytes E0 14, then 14, then E0 F0 14 -> ctrl=1; ctrl stays 1 while the left ctrl is held; the right release alone leaves ctrl=1.
REQ-032 Bytes 58, 58, F0 58, 58 -> caps becomes 1, stays 1 on the repeat, stays 1 after the break, and becomes 0 on the second press.
REQ-033 overflow=1 together with ready=1, after F0 and key=0x1C -> set_rst=1 for one cycle, set_next=0, key=0x00, brk cleared; a following byte 0x1C is treated as a make.
REQ-034 rst pulse asserted asynchronously between clock edges with shift=1 and caps=1 -> all outputs go to 0 immediately, without waiting for a clock edge.
